// File: rtl/an_pkg.sv
// an_pkg: shared definitions for the AN-code encoder slice.
//   - default code/data/counter widths and the default code constant A
//   - FSM state encoding used by an_encoder
//   - an_mask(): one-hot codeword error mask, zero when the index is out of range
package an_pkg;

  localparam int unsigned AN_A          = 19;
  localparam int unsigned AN_N_W        = 4;
  localparam int unsigned AN_CODE_W     = 9;
  localparam int unsigned AN_CNT_W      = 16;

  // Widest codeword an_mask can describe; callers truncate to their CODE_W.
  localparam int unsigned AN_MASK_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } an_state_e;

  // One-hot mask at bit_idx, or all-zero when bit_idx falls outside the codeword.
  function automatic logic [AN_MASK_MAX_W-1:0] an_mask(
    input int unsigned bit_idx,
    input int unsigned code_w = AN_CODE_W
  );
    logic [AN_MASK_MAX_W-1:0] m;
    m = '0;
    if ((bit_idx < code_w) && (bit_idx < AN_MASK_MAX_W)) begin
      m = AN_MASK_MAX_W'(1) << bit_idx;
    end
    return m;
  endfunction

endpackage

// File: rtl/an_encoder_if.sv
// an_encoder_if: stream bundle around the AN encoder.
//   Input channel : in_valid/in_ready handshake carrying in_data, inj_en, inj_bit.
//   Output channel: out_valid/out_ready handshake carrying out_code, out_injected.
// Modports:
//   master - the environment: offers data words, consumes codewords.
//   slave  - the encoder itself.
interface an_encoder_if
  import an_pkg::*;
#(
  parameter int unsigned N_W    = AN_N_W,
  parameter int unsigned CODE_W = AN_CODE_W,
  parameter int unsigned IB_W   = $clog2(CODE_W) + 1
) ();

  logic              in_valid;
  logic              in_ready;
  logic [N_W-1:0]    in_data;
  logic              inj_en;
  logic [IB_W-1:0]   inj_bit;

  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_injected;

  modport master (
    output in_valid, in_data, inj_en, inj_bit, out_ready,
    input  in_ready, out_valid, out_code, out_injected
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_bit, out_ready,
    output in_ready, out_valid, out_code, out_injected
  );

endinterface

// File: rtl/an_err_mask.sv
// an_err_mask: combinational single-bit error mask generator.
// Ports:
//   inj_en  in  - request a flip
//   inj_bit in  - codeword bit index to flip
//   mask    out - one-hot at inj_bit when inj_en and inj_bit < CODE_W, else zero
module an_err_mask
  import an_pkg::*;
#(
  parameter int unsigned CODE_W = AN_CODE_W,
  parameter int unsigned IB_W   = $clog2(CODE_W) + 1
) (
  input  logic              inj_en,
  input  logic [IB_W-1:0]   inj_bit,
  output logic [CODE_W-1:0] mask
);

  always_comb begin
    mask = '0;
    if (inj_en) begin
      mask = CODE_W'(an_mask(32'(inj_bit), CODE_W));
    end
  end

endmodule

// File: rtl/an_encoder.sv
// an_encoder: sequential AN-code encoder (codeword = A*N), one data bit per cycle.
// Ports:
//   clk       in  - single clock, rising edge
//   rst_n     in  - asynchronous active-low reset
//   bus       slave modport of an_encoder_if (input/output handshakes)
//   word_cnt  out - codewords delivered, saturating
//   err_cnt   out - codewords delivered with a flipped bit, saturating
// Flow: IDLE accepts a word, MUL adds A<<i for each set data bit, DONE holds the
// codeword until the downstream handshake. in_ready/out_valid decode the state only.
module an_encoder
  import an_pkg::*;
#(
  parameter int unsigned A      = AN_A,
  parameter int unsigned N_W    = AN_N_W,
  parameter int unsigned CODE_W = AN_CODE_W,
  parameter int unsigned CNT_W  = AN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  an_encoder_if.slave      bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned IB_W   = $clog2(CODE_W) + 1;
  localparam int unsigned IDX_W  = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_W - 1);
  localparam longint unsigned MAX_PRODUCT = longint'(A) * ((64'd1 << N_W) - 64'd1);

  // Parameter legality is resolved at elaboration.
  if ((A < 3) || ((A % 2) == 0)) begin : g_bad_a
    $error("an_encoder: A must be odd and >= 3");
  end
  if ((CODE_W > 62) || (MAX_PRODUCT >= (64'd1 << CODE_W))) begin : g_bad_code_w
    $error("an_encoder: A*(2^N_W-1) must fit in CODE_W bits");
  end

  localparam logic [CODE_W-1:0] A_CODE = CODE_W'(A);

  an_state_e         state_q, state_d;
  logic [N_W-1:0]    d_q, d_d;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              inj_en_q, inj_en_d;
  logic [IB_W-1:0]   inj_bit_q, inj_bit_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic              out_injected_q, out_injected_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [CODE_W-1:0] err_mask;
  logic [CODE_W-1:0] acc_sum;

  an_err_mask #(
    .CODE_W (CODE_W),
    .IB_W   (IB_W)
  ) u_err_mask (
    .inj_en  (inj_en_q),
    .inj_bit (inj_bit_q),
    .mask    (err_mask)
  );

  // Shift-and-add step: the parameter check guarantees no carry out of CODE_W.
  assign acc_sum = d_q[0] ? (acc_q + (A_CODE << i_q)) : acc_q;

  always_comb begin
    state_d        = state_q;
    d_d            = d_q;
    acc_d          = acc_q;
    i_d            = i_q;
    inj_en_d       = inj_en_q;
    inj_bit_d      = inj_bit_q;
    out_code_d     = out_code_q;
    out_injected_d = out_injected_q;
    word_cnt_d     = word_cnt_q;
    err_cnt_d      = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          d_d       = bus.in_data;
          inj_en_d  = bus.inj_en;
          inj_bit_d = bus.inj_bit;
          acc_d     = '0;
          i_d       = '0;
          state_d   = MUL;
        end
      end

      MUL: begin
        acc_d = acc_sum;
        d_d   = d_q >> 1;
        i_d   = i_q + IDX_W'(1);
        if (i_q == LAST_I) begin
          out_code_d     = acc_sum ^ err_mask;
          out_injected_d = |err_mask;
          state_d        = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          if (word_cnt_q != '1) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
          if (out_injected_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset aborts any word in flight; the codeword register is cleared too, so a
  // partial result can never appear on out_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      d_q            <= '0;
      acc_q          <= '0;
      i_q            <= '0;
      inj_en_q       <= 1'b0;
      inj_bit_q      <= '0;
      out_code_q     <= '0;
      out_injected_q <= 1'b0;
      word_cnt_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      d_q            <= d_d;
      acc_q          <= acc_d;
      i_q            <= i_d;
      inj_en_q       <= inj_en_d;
      inj_bit_q      <= inj_bit_d;
      out_code_q     <= out_code_d;
      out_injected_q <= out_injected_d;
      word_cnt_q     <= word_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_code     = out_code_q;
  assign bus.out_injected = out_injected_q;
  assign word_cnt         = word_cnt_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_an_encoder.sv
// Testbench for an_encoder: directed cases followed by randomized words, all
// checked against a plain arithmetic model (A*N xor flip, saturating counts).
module tb_an_encoder;

  localparam int unsigned A      = 19;
  localparam int unsigned N_W    = 4;
  localparam int unsigned CODE_W = 9;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IB_W   = $clog2(CODE_W) + 1;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;

  an_encoder_if #(.N_W(N_W), .CODE_W(CODE_W)) bus ();

  an_encoder #(
    .A      (A),
    .N_W    (N_W),
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .word_cnt (word_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_miscmp  = 0;
  int mdl_words = 0;
  int mdl_errs  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
    check_val("word_cnt", 64'(word_cnt), 64'(mdl_words));
    check_val("err_cnt", 64'(err_cnt), 64'(mdl_errs));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_val({tag, "_out_code"}, 64'(bus.out_code), 64'd0);
    check_val({tag, "_out_inj"}, 64'(bus.out_injected), 64'd0);
    check_val({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    check_val({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  // Offer one word, follow it through latency, an optional stall, and delivery.
  task automatic do_word(input int n, input bit en, input int bidx, input int stall);
    longint exp_code;
    bit     exp_inj;
    exp_inj  = en && (bidx < int'(CODE_W));
    exp_code = longint'(A) * longint'(n);
    if (exp_inj) exp_code = exp_code ^ (longint'(1) << bidx);

    check_val("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = N_W'(n);
    bus.inj_en   = en;
    bus.inj_bit  = IB_W'(bidx);
    @(posedge clk); #1;
    // Scramble the input side: none of it may leak into this word.
    bus.in_valid = 1'b0;
    bus.in_data  = N_W'($urandom);
    bus.inj_en   = 1'($urandom);
    bus.inj_bit  = IB_W'($urandom);

    for (int k = 1; k <= int'(N_W); k++) begin
      bus.out_ready = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      @(posedge clk); #1;
      check_val("out_valid_latency", 64'(bus.out_valid), 64'(k == int'(N_W)));
      check_val("in_ready_busy", 64'(bus.in_ready), 64'd0);
    end

    for (int s = 0; s < stall; s++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom);
      bus.in_data   = N_W'($urandom);
      @(posedge clk); #1;
      check_val("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check_val("stall_out_code", 64'(bus.out_code), 64'(exp_code));
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_val("out_code", 64'(bus.out_code), 64'(exp_code));
    check_val("out_injected", 64'(bus.out_injected), 64'(exp_inj));
    @(posedge clk); #1;
    if (mdl_words < CMAX) mdl_words++;
    if (exp_inj && (mdl_errs < CMAX)) mdl_errs++;
    bus.out_ready = 1'b0;
    check_val("in_ready_after", 64'(bus.in_ready), 64'd1);
    check_val("out_valid_after", 64'(bus.out_valid), 64'd0);
    check_counters();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_en    = 1'b0;
    bus.inj_bit   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain encode, then the three single-bit flips on the same word.
    do_word(11, 1'b0, 0, 0);
    check_val("n11_word_cnt", 64'(word_cnt), 64'd1);
    do_word(11, 1'b1, 1, 0);
    do_word(11, 1'b1, 8, 0);
    do_word(11, 1'b1, 0, 0);
    check_val("n11_err_cnt", 64'(err_cnt), 64'd3);

    do_word(15, 1'b0, 0, 0);
    do_word(0, 1'b1, 4, 0);
    // Out-of-range index: no flip, err_cnt holds.
    do_word(11, 1'b1, 12, 0);
    check_val("oor_err_cnt", 64'(err_cnt), 64'd4);

    // Backpressure for 10 cycles.
    do_word(6, 1'b1, 3, 10);

    // Reset two cycles after an accept aborts the word.
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = N_W'(7);
    bus.inj_en   = 1'b1;
    bus.inj_bit  = IB_W'(2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    mdl_words = 0;
    mdl_errs  = 0;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_word(11, 1'b0, 0, 0);
    check_val("post_rst_word_cnt", 64'(word_cnt), 64'd1);

    // Randomized words; enough of them to drive both counters into saturation.
    for (int w = 0; w < 60; w++) begin
      do_word(int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 13)), int'($urandom_range(0, 3)));
    end
    check_val("sat_word_cnt", 64'(word_cnt), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/an_encoder.md
# an_encoder

Sequential AN-code encoder: the stage directly upstream of `ANdecoder`. It accepts an N_W-bit data word over a valid/ready handshake and forms the codeword A·N with a shift-and-add multiplier, one data bit per cycle. It can optionally flip one codeword bit so that bit-error-rate runs drive the decoder with known single-bit errors. Saturating counters record the number of words encoded and the number of errors injected.

## Interface
- `A`, 19, code constant; odd, ≥3
- `N_W`, 4, data width
- `CODE_W`, 9, codeword width; must satisfy A·(2^N_W−1) < 2^CODE_W (elaboration error otherwise)
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  data word offered
- `in_ready`  out  1  encoder can accept; high only in IDLE
- `in_data`  in  N_W  data word N
- `inj_en`  in  1  inject a single-bit error into this word; sampled with `in_data`
- `inj_bit`  in  $clog2(CODE_W)+1  codeword bit index to flip; sampled with `in_data`
- `out_valid`  out  1  codeword held on `out_code`
- `out_ready`  in  1  downstream (decoder) consumes codeword
- `out_code`  out  CODE_W  A·N, XOR error mask
- `out_injected`  out  1  a bit was actually flipped in `out_code`
- `word_cnt`  out  CNT_W  codewords delivered, saturating
- `err_cnt`  out  CNT_W  codewords delivered with `out_injected`=1, saturating

## Operation
- States: IDLE → MUL → DONE → IDLE.
- IDLE: `in_ready`=1. On the edge where `in_valid`&&`in_ready`, the encoder:
  - latches `in_data` into shift register `d`, plus `inj_en` and `inj_bit`;
  - clears accumulator `acc` and bit counter `i`;
  - moves to MUL.
- MUL: each edge, if `d[0]` then `acc += A<<i`; `d >>= 1`; `i++`. Arithmetic is at CODE_W bits; overflow cannot occur under the parameter rule.
- On the edge that processes bit `i`=N_W−1:
  - `out_code` ← final sum XOR mask. The mask is one-hot at `inj_bit` when `inj_en`=1 and `inj_bit`<CODE_W, otherwise zero.
  - `out_injected` ← (mask≠0).
  - State moves to DONE.
- DONE: `out_valid`=1. `out_code` and `out_injected` stay stable until `out_valid`&&`out_ready`. On that edge:
  - state → IDLE;
  - `word_cnt` increments; `err_cnt` increments if `out_injected`=1;
  - each counter holds at all-ones instead of wrapping.
- `inj_bit` ≥ CODE_W: no flip, `out_injected`=0, `err_cnt` unchanged.
- `in_data`=0: the code is 0 (plus mask). This is legal.
- Inputs offered outside IDLE are ignored, because `in_ready`=0.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1;
  - `out_valid`=0, `out_code`=0, `out_injected`=0;
  - `word_cnt`=0, `err_cnt`=0;
  - internal `acc`, `d`, `i` = 0.
- Reset asserted mid-MUL or mid-DONE aborts the word immediately. No partial codeword is ever delivered.
- Latency: with the accept edge as edge 0, `out_valid` is high after edge N_W (4 cycles by default).
- `in_ready` returns high the cycle after the output handshake edge.
- Minimum period per word: N_W+2 cycles with `out_ready` tied high. There is no accept/deliver overlap.
- `out_ready` high before `out_valid` has no effect. `out_ready` low stalls DONE indefinitely.
- All outputs are registered except `in_ready` and `out_valid`, which are decoded from the state register only, with no input-to-output combinational path.

## Structure
- Package `an_pkg`:
  - default A, N_W, CODE_W, CNT_W constants;
  - state enum {IDLE, MUL, DONE};
  - function `an_mask(bit_idx)` returning the one-hot CODE_W mask (zero when out of range).
- Sub-module `an_err_mask`: combinational one-hot mask generator from `inj_en`/`inj_bit`. It is reused later by the standalone error-injection bench.
- Everything else (FSM, shift-add datapath, counters) stays in `an_encoder`.

## Test plan
- Reset, then N=11 with `inj_en`=0, `out_ready`=1:
  - `out_valid` rises 4 cycles after accept;
  - `out_code`=209, `out_injected`=0, `word_cnt`=1.
- N=11 with `inj_en`=1 at `inj_bit`=1, 8 and 0, in turn:
  - `out_code`=211, then 465, then 208;
  - `err_cnt`=3 afterwards.
- N=15 with no injection gives `out_code`=285. N=0 with `inj_bit`=4 gives `out_code`=16 and `out_injected`=1.
- `inj_en`=1 with `inj_bit`=12 (out of range) gives `out_code`=A·N unflipped, `out_injected`=0, and `err_cnt` unchanged.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles; `out_code` stays stable and `in_ready` stays 0;
  - change `in_data` meanwhile; it is ignored;
  - release; the handshake completes and `in_ready`=1 the next cycle.
- Reset checks:
  - assert `rst_n` low two cycles after an accept; all outputs go to their reset values immediately and the next word encodes correctly;
  - force `word_cnt` near all-ones (CNT_W=4 build); it saturates at 15.
